cpu_imem_arbiter: RTL and testbench

- Owns the single-port 48-bit instruction BRAM behind the hatch interface.
- Shares the BRAM between the fetch stage (reads every cycle) and a program loader (host/UART bursts of reads and writes).
- Sequences the core during a load: freezes fetch, grants the loader, then holds the core in reset so it restarts cleanly at address 0.

---
 rtl/cpu_imem_arbiter_pkg.sv | 16 +
 rtl/cpu_imem_arbiter_if.sv | 40 ++++
 rtl/cpu_restart_timer.sv | 35 +++
 rtl/cpu_imem_arbiter.sv | 117 +++++++++++
 tb/tb_cpu_imem_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_imem_arbiter_pkg.sv
// cpu_defs: shared instruction width, IMEM geometry and the
// arbiter state encoding.
package cpu_defs;

    localparam int INSN_W = 48;
    localparam int IMEM_ADDR_W = 11;
    localparam logic [INSN_W-1:0] NOP_INSN = 48'h0;

    typedef enum logic [1:0] {
        IMEM_RUN     = 2'd0,
        IMEM_QUIESCE = 2'd1,
        IMEM_LOAD    = 2'd2,
        IMEM_RESTART = 2'd3
    } imem_state_t;

endpackage

// File: rtl/cpu_imem_arbiter_if.sv
// Loader port of the IMEM arbiter: ownership request, burst access
// and read-return path.
interface cpu_imem_arbiter_if
    import cpu_defs::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) ();

    logic              ld_req;
    logic              ld_done;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [INSN_W-1:0] ld_wdata;
    logic              ld_grant;
    logic [INSN_W-1:0] ld_rdata;
    logic              ld_rvalid;

    modport master (
        output ld_req,
        output ld_done,
        output ld_we,
        output ld_addr,
        output ld_wdata,
        input  ld_grant,
        input  ld_rdata,
        input  ld_rvalid
    );

    modport slave (
        input  ld_req,
        input  ld_done,
        input  ld_we,
        input  ld_addr,
        input  ld_wdata,
        output ld_grant,
        output ld_rdata,
        output ld_rvalid
    );

endinterface

// File: rtl/cpu_restart_timer.sv
// Down-counter that holds the core in reset for CYCLES cycles
// after a load burst; start loads it, done marks the last cycle.
module cpu_restart_timer #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst_b,
    input  logic start,
    output logic done
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt;
    logic          busy;

    always_ff @(posedge clk) begin
        if (rst_b) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            cnt  <= CW'(CYCLES - 1);
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done = busy && (cnt == '0);

endmodule

// File: rtl/cpu_imem_arbiter.sv
// Single-port instruction BRAM arbiter: fetch owns it in RUN, the
// loader owns it in LOAD, and the core restarts from reset afterwards.
module cpu_imem_arbiter
    import cpu_defs::INSN_W, cpu_defs::IMEM_ADDR_W,
           cpu_defs::imem_state_t,
           cpu_defs::IMEM_RUN, cpu_defs::IMEM_QUIESCE,
           cpu_defs::IMEM_LOAD, cpu_defs::IMEM_RESTART;
#(
    parameter int                ADDR_W         = IMEM_ADDR_W,
    parameter int                RESTART_CYCLES = 4,
    parameter logic [INSN_W-1:0] NOP_INSN       = cpu_defs::NOP_INSN
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [31:0]        hatch_address,
    output logic [INSN_W-1:0]  hatch_instruction,
    output logic               f_valid,
    output logic               f_fault,
    output logic               f_hold,
    output logic               core_rst,
    cpu_imem_arbiter_if.slave  ld,
    output logic               m_en,
    output logic               m_we,
    output logic [ADDR_W-1:0]  m_addr,
    output logic [INSN_W-1:0]  m_wdata,
    input  logic [INSN_W-1:0]  m_rdata
);

    imem_state_t state;
    imem_state_t state_nx;

    logic oor;
    logic ld_rd;
    logic grant_q;
    logic rvalid_q;
    logic tmr_start;
    logic tmr_done;

    assign oor   = |hatch_address[31:ADDR_W];
    assign ld_rd = (state == IMEM_LOAD) && ld.ld_req && !ld.ld_we;

    assign tmr_start = (state == IMEM_LOAD) && ld.ld_done;

    cpu_restart_timer #(
        .CYCLES (RESTART_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_b (rst_b),
        .start (tmr_start),
        .done  (tmr_done)
    );

    // Status flags are registered from the next state so they line
    // up with the state the arbiter is in during that cycle.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state    <= IMEM_RUN;
            f_hold   <= 1'b0;
            core_rst <= 1'b0;
            grant_q  <= 1'b0;
            f_valid  <= 1'b0;
            f_fault  <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state    <= state_nx;
            f_hold   <= (state_nx != IMEM_RUN);
            core_rst <= (state_nx == IMEM_RESTART);
            grant_q  <= (state_nx == IMEM_LOAD);
            f_valid  <= (state == IMEM_RUN);
            f_fault  <= (state == IMEM_RUN) && oor;
            rvalid_q <= ld_rd;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IMEM_RUN:
                if (ld.ld_req) state_nx = IMEM_QUIESCE;
            IMEM_QUIESCE:
                state_nx = IMEM_LOAD;
            IMEM_LOAD:
                if (ld.ld_done) state_nx = IMEM_RESTART;
            IMEM_RESTART:
                if (tmr_done) state_nx = IMEM_RUN;
        endcase
    end

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = hatch_address[ADDR_W-1:0];
        m_wdata = ld.ld_wdata;
        if (!rst_b) begin
            unique case (state)
                IMEM_RUN: begin
                    m_en = !oor;
                end
                IMEM_LOAD: begin
                    m_en   = ld.ld_req;
                    m_we   = ld.ld_req && ld.ld_we;
                    m_addr = ld.ld_addr;
                end
                IMEM_QUIESCE, IMEM_RESTART: begin
                    m_en = 1'b0;
                end
            endcase
        end
    end

    assign hatch_instruction = f_fault ? NOP_INSN : m_rdata;

    assign ld.ld_grant  = grant_q;
    assign ld.ld_rvalid = rvalid_q;
    assign ld.ld_rdata  = m_rdata;

endmodule

// File: tb/tb_cpu_imem_arbiter.sv
// Bench for cpu_imem_arbiter: vector table per cycle, BRAM model,
// and a scoreboard of expected fetch / loader read returns.
module tb_cpu_imem_arbiter;

    localparam int AW = 11;
    localparam logic [47:0] NOP = 48'h0;
    localparam logic [47:0] Z = 48'h0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_b;
    logic [31:0]   hatch_address;
    logic [47:0]   hatch_instruction;
    logic          f_valid;
    logic          f_fault;
    logic          f_hold;
    logic          core_rst;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [47:0]   m_wdata;
    logic [47:0]   m_rdata;

    cpu_imem_arbiter_if #(.ADDR_W(AW)) ld_if ();

    cpu_imem_arbiter #(
        .ADDR_W         (AW),
        .RESTART_CYCLES (4),
        .NOP_INSN       (NOP)
    ) dut (
        .clk               (clk),
        .rst_b             (rst_b),
        .hatch_address     (hatch_address),
        .hatch_instruction (hatch_instruction),
        .f_valid           (f_valid),
        .f_fault           (f_fault),
        .f_hold            (f_hold),
        .core_rst          (core_rst),
        .ld                (ld_if),
        .m_en              (m_en),
        .m_we              (m_we),
        .m_addr            (m_addr),
        .m_wdata           (m_wdata),
        .m_rdata           (m_rdata)
    );

    function automatic logic [47:0] initw(int i);
        if (i == 5) return 48'hABCD_0000_1234;
        return {8'hA5, 29'(i), 11'(i)};
    endfunction

    // BRAM model, read-first, 1-cycle latency
    logic [47:0] mem [0:2047];
    logic        mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= initw(i);
            mem_init <= 1'b1;
        end else if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            m_rdata <= mem[m_addr];
        end
    end

    typedef struct {
        logic        rst;
        logic [31:0] ha;
        logic        req;
        logic        done;
        logic        we;
        logic [10:0] la;
        logic [47:0] wd;
        logic        fetch;
        logic        hold;
        logic        grant;
        logic        crst;
        logic        men;
        logic        mwe;
    } vec_t;

    typedef struct {
        int          tag;
        logic [47:0] d;
        logic        f;
    } exp_t;

    vec_t        vecs[$];
    exp_t        fq[$];
    exp_t        lq[$];
    logic [47:0] shadow [0:2047];
    int          cyc;
    int          total;
    int          passed;

    function automatic void add(
        int r, int ha, int rq, int dn, int we, int la,
        logic [47:0] wd, int fe,
        int ho, int gr, int cr, int me, int mw);
        vec_t v;
        v.rst   = 1'(r);
        v.ha    = 32'(ha);
        v.req   = 1'(rq);
        v.done  = 1'(dn);
        v.we    = 1'(we);
        v.la    = 11'(la);
        v.wd    = wd;
        v.fetch = 1'(fe);
        v.hold  = 1'(ho);
        v.grant = 1'(gr);
        v.crst  = 1'(cr);
        v.men   = 1'(me);
        v.mwe   = 1'(mw);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s @%0d: got %h want %h",
                      nm, cyc, act, exp);
    endtask

    task automatic check_out();
        exp_t e;
        chk("rvalid_fvalid_excl",
            64'(f_valid && ld_if.ld_rvalid), 64'(0));
        if (fq.size() > 0 && fq[0].tag == cyc - 1) begin
            e = fq.pop_front();
            chk("f_valid", 64'(f_valid), 64'(1));
            chk("hatch_insn", 64'(hatch_instruction), 64'(e.d));
            chk("f_fault", 64'(f_fault), 64'(e.f));
        end else begin
            chk("f_valid_idle", 64'(f_valid), 64'(0));
        end
        if (lq.size() > 0 && lq[0].tag == cyc - 1) begin
            e = lq.pop_front();
            chk("ld_rvalid", 64'(ld_if.ld_rvalid), 64'(1));
            chk("ld_rdata", 64'(ld_if.ld_rdata), 64'(e.d));
        end else begin
            chk("ld_rvalid_idle", 64'(ld_if.ld_rvalid), 64'(0));
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        logic oor;
        @(posedge clk);
        #1;
        cyc++;
        check_out();
        chk("f_hold", 64'(f_hold), 64'(v.hold));
        chk("ld_grant", 64'(ld_if.ld_grant), 64'(v.grant));
        chk("core_rst", 64'(core_rst), 64'(v.crst));
        rst_b          = v.rst;
        hatch_address  = v.ha;
        ld_if.ld_req   = v.req;
        ld_if.ld_done  = v.done;
        ld_if.ld_we    = v.we;
        ld_if.ld_addr  = v.la;
        ld_if.ld_wdata = v.wd;
        #1;
        chk("m_en", 64'(m_en), 64'(v.men));
        chk("m_we", 64'(m_we), 64'(v.mwe));
        if (v.men)
            chk("m_addr", 64'(m_addr),
                64'(v.grant ? v.la : v.ha[10:0]));
        if (v.mwe)
            chk("m_wdata", 64'(m_wdata), 64'(v.wd));
        if (v.fetch) begin
            oor   = |v.ha[31:11];
            e.tag = cyc;
            e.f   = oor;
            e.d   = oor ? NOP : shadow[v.ha[10:0]];
            fq.push_back(e);
        end
        if (!v.rst && v.grant && v.req) begin
            if (v.we) begin
                shadow[v.la] = v.wd;
            end else begin
                e.tag = cyc;
                e.f   = 1'b0;
                e.d   = shadow[v.la];
                lq.push_back(e);
            end
        end
    endtask

    initial begin
        cyc    = 0;
        total  = 0;
        passed = 0;
        for (int i = 0; i < 2048; i++) shadow[i] = initw(i);

        // r  ha  rq dn we la  wd  fe  ho gr cr me mw
        add(0, 5, 0, 0, 0, 0, Z, 1, 0, 0, 0, 1, 0);
        add(0, 32'h800, 0, 0, 0, 0, Z, 1, 0, 0, 0, 0, 0);
        add(0, 7, 0, 0, 0, 0, Z, 1, 0, 0, 0, 1, 0);
        add(0, 32'hFFFF_FFFF, 0, 0, 0, 0, Z, 1,
            0, 0, 0, 0, 0);
        add(0, 32'h7FF, 0, 0, 0, 0, Z, 1, 0, 0, 0, 1, 0);
        add(0, 32'h8000_0000, 0, 0, 0, 0, Z, 1,
            0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, Z, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, Z, 1, 0, 0, 0, 1, 0);
        add(0, 3, 0, 0, 0, 0, Z, 1, 0, 0, 0, 1, 0);
        add(0, 4, 0, 0, 0, 0, Z, 1, 0, 0, 0, 1, 0);
        // load request; last fetch still completes
        add(0, 6, 1, 0, 0, 0, Z, 1, 0, 0, 0, 1, 0);
        add(0, 6, 1, 0, 1, 3, 48'h1, 0, 1, 0, 0, 0, 0);
        add(0, 6, 1, 0, 1, 3, 48'h1, 0, 1, 1, 0, 1, 1);
        add(0, 6, 1, 0, 0, 3, Z, 0, 1, 1, 0, 1, 0);
        add(0, 6, 1, 0, 1, 0, 48'hBEEF, 0, 1, 1, 0, 1, 1);
        add(0, 6, 0, 0, 1, 9, 48'h9, 0, 1, 1, 0, 0, 0);
        add(0, 6, 1, 0, 1, 11'h7FF, 48'hFFFF_FFFF_FFFF, 0,
            1, 1, 0, 1, 1);
        add(0, 6, 1, 0, 0, 0, Z, 0, 1, 1, 0, 1, 0);
        add(0, 6, 1, 0, 1, 5, 48'h5555_AAAA_5555, 0,
            1, 1, 0, 1, 1);
        add(0, 6, 0, 0, 0, 0, Z, 0, 1, 1, 0, 0, 0);
        // done with a same-cycle read
        add(0, 6, 1, 1, 0, 5, Z, 0, 1, 1, 0, 1, 0);
        add(0, 6, 1, 0, 0, 1, Z, 0, 1, 0, 1, 0, 0);
        add(0, 6, 1, 0, 0, 1, Z, 0, 1, 0, 1, 0, 0);
        add(0, 6, 0, 0, 0, 0, Z, 0, 1, 0, 1, 0, 0);
        add(0, 6, 0, 0, 0, 0, Z, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, Z, 1, 0, 0, 0, 1, 0);
        add(0, 5, 0, 0, 0, 0, Z, 1, 0, 0, 0, 1, 0);
        // second load; ld_req held through RESTART
        add(0, 3, 1, 0, 0, 0, Z, 1, 0, 0, 0, 1, 0);
        add(0, 3, 1, 0, 0, 0, Z, 0, 1, 0, 0, 0, 0);
        add(0, 3, 1, 1, 0, 11'h7FF, Z, 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            add(0, 3, 1, 0, 0, 0, Z, 0, 1, 0, 1, 0, 0);
        add(0, 32'h7FF, 1, 0, 0, 0, Z, 1, 0, 0, 0, 1, 0);
        add(0, 32'h7FF, 1, 0, 0, 0, Z, 0, 1, 0, 0, 0, 0);
        // reset while in LOAD
        add(1, 32'h7FF, 1, 0, 1, 9, 48'h9, 0, 1, 1, 0, 0, 0);
        add(0, 3, 0, 0, 0, 0, Z, 1, 0, 0, 0, 1, 0);
        add(0, 32'h7FF, 0, 0, 0, 0, Z, 1, 0, 0, 0, 1, 0);

        rst_b          = 1'b1;
        hatch_address  = 32'd5;
        ld_if.ld_req   = 1'b0;
        ld_if.ld_done  = 1'b0;
        ld_if.ld_we    = 1'b0;
        ld_if.ld_addr  = '0;
        ld_if.ld_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_f_hold", 64'(f_hold), 64'(0));
        chk("rst_core_rst", 64'(core_rst), 64'(0));
        chk("rst_f_valid", 64'(f_valid), 64'(0));
        chk("rst_f_fault", 64'(f_fault), 64'(0));
        chk("rst_ld_grant", 64'(ld_if.ld_grant), 64'(0));
        chk("rst_ld_rvalid", 64'(ld_if.ld_rvalid), 64'(0));
        chk("rst_m_en", 64'(m_en), 64'(0));
        chk("rst_m_we", 64'(m_we), 64'(0));

        foreach (vecs[i]) apply(vecs[i]);

        @(posedge clk);
        #1;
        cyc++;
        check_out();
        chk("queues_drained", 64'(fq.size() + lq.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
